// File: rtl/step_input_conditioner.sv
// Step-button debouncer and switch synchronizer between the board pins and the CPU.
// Optional auto-repeat while the button is held: define BTN_AUTO_REPEAT_EN.
module step_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20,
  parameter int SW_W            = 6,
  parameter int REPEAT_CYCLES   = 50_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btn_raw,
  input  logic [SW_W-1:0] sw_raw,
  output logic [SW_W-1:0] sw_sync,
  output logic            step_pulse,
  output logic            btn_level,
  output logic [15:0]     step_count
);

  // Handshake note: there is none; step_pulse is a single-cycle strobe, step_count
  // advances on the same edge, and btn_level is a plain registered level.

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_HELD         = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } state_t;

  // The IDLE sample that opens a press already counts as one stable cycle, so the
  // press window closes one count earlier than the release window.
  localparam bit             C_DIRECT     = (DEBOUNCE_CYCLES == 1);
  localparam logic [CNT_W-1:0] C_PRESS_LAST =
    CNT_W'((DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] C_REL_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic            r_btn_meta;
  logic            r_btn_s;
  logic [SW_W-1:0] r_sw_meta;
  logic [SW_W-1:0] r_sw_s;

  state_t          r_state;
  state_t          w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic            w_pulse;
  logic            w_next_level;
  logic            r_pulse;
  logic            r_level;
  logic [15:0]     r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_meta <= 1'b0;
      r_btn_s    <= 1'b0;
      r_sw_meta  <= '0;
      r_sw_s     <= '0;
    end else begin
      r_btn_meta <= btn_raw;
      r_btn_s    <= r_btn_meta;
      r_sw_meta  <= sw_raw;
      r_sw_s     <= r_sw_meta;
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] C_REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] r_rep;
  logic [CNT_W-1:0] w_next_rep;
`endif

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_pulse      = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
    w_next_rep   = r_rep;
`endif
    case (r_state)
      S_IDLE: begin
        if (r_btn_s) begin
          w_next_cnt = '0;
          if (C_DIRECT) begin
            w_next_state = S_HELD;
            w_pulse      = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
            w_next_rep   = '0;
`endif
          end else begin
            w_next_state = S_PRESS_WAIT;
          end
        end
      end
      S_PRESS_WAIT: begin
        if (!r_btn_s) begin
          w_next_state = S_IDLE;
        end else if (r_cnt == C_PRESS_LAST) begin
          w_next_state = S_HELD;
          w_pulse      = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
          w_next_rep   = '0;
`endif
        end else begin
          w_next_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_HELD: begin
        if (!r_btn_s) begin
          w_next_state = S_RELEASE_WAIT;
          w_next_cnt   = '0;
        end else begin
`ifdef BTN_AUTO_REPEAT_EN
          if (r_rep == C_REP_LAST) begin
            w_pulse    = 1'b1;
            w_next_rep = '0;
          end else begin
            w_next_rep = r_rep + CNT_W'(1);
          end
`endif
        end
      end
      S_RELEASE_WAIT: begin
        // Repeat counter holds here; it is restarted only when HELD is re-entered.
        if (r_btn_s) begin
          w_next_state = S_HELD;
`ifdef BTN_AUTO_REPEAT_EN
          w_next_rep   = '0;
`endif
        end else if (r_cnt == C_REL_LAST) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_cnt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = '0;
      end
    endcase
    w_next_level = (w_next_state == S_HELD) || (w_next_state == S_RELEASE_WAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
      r_level <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_pulse <= w_pulse;
      r_level <= w_next_level;
      r_count <= r_count + 16'(w_pulse);
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rep <= '0;
    end else begin
      r_rep <= w_next_rep;
    end
  end
`endif

  assign sw_sync    = r_sw_s;
  assign step_pulse = r_pulse;
  assign btn_level  = r_level;
  assign step_count = r_count;

endmodule

// File: tb/tb_step_input_conditioner.sv
// Self-checking bench for step_input_conditioner: directed scenarios plus random
// press/release traffic, compared every cycle against a run-length reference model.
module tb_step_input_conditioner;

  localparam int D    = 4;
  localparam int R    = 10;
  localparam int CW   = 4;
  localparam int SW_W = 6;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            btn_raw = 1'b0;
  logic [SW_W-1:0] sw_raw = '0;
  logic [SW_W-1:0] sw_sync;
  logic            step_pulse;
  logic            btn_level;
  logic [15:0]     step_count;

  int n_assert = 0;
  int n_fail   = 0;

  step_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(CW),
    .SW_W(SW_W),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .sw_raw(sw_raw),
    .sw_sync(sw_sync),
    .step_pulse(step_pulse),
    .btn_level(btn_level),
    .step_count(step_count)
  );

  always #5 clk = ~clk;

  // Reference model: a press is accepted after D consecutive synchronized 1-samples,
  // a release after D+1 consecutive 0-samples; auto-repeat every R held samples.
  logic            m_raw1, m_raw2;
  logic [SW_W-1:0] m_sw1, m_sw2;
  logic            m_level, m_pulse;
  int              m_run, m_rep;
  logic [15:0]     m_count;
  int              n_pulses;

  task automatic model_reset();
    m_raw1 = 0; m_raw2 = 0; m_sw1 = '0; m_sw2 = '0;
    m_level = 0; m_pulse = 0; m_run = 0; m_rep = 0; m_count = '0;
  endtask

  task automatic model_step(input logic b, input logic [SW_W-1:0] sw);
    logic s;
    s = m_raw2;
    m_pulse = 0;
    if (!m_level) begin
      m_run = s ? m_run + 1 : 0;
      if (m_run == D) begin
        m_level = 1; m_run = 0; m_rep = 0; m_pulse = 1;
      end
    end else if (!s) begin
      m_run = m_run + 1;
      if (m_run == D + 1) begin
        m_level = 0; m_run = 0;
      end
    end else if (m_run > 0) begin
      m_run = 0; m_rep = 0;
    end else begin
`ifdef BTN_AUTO_REPEAT_EN
      m_rep = m_rep + 1;
      if (m_rep == R) begin
        m_rep = 0; m_pulse = 1;
      end
`endif
    end
    if (m_pulse) m_count = m_count + 16'd1;
    m_raw2 = m_raw1; m_raw1 = b;
    m_sw2 = m_sw1; m_sw1 = sw;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pulse"}, {31'd0, step_pulse}, {31'd0, m_pulse});
    chk({tag, ".level"}, {31'd0, btn_level}, {31'd0, m_level});
    chk({tag, ".count"}, {16'd0, step_count}, {16'd0, m_count});
    chk({tag, ".sw"}, {26'd0, sw_sync}, {26'd0, m_sw2});
  endtask

  task automatic tick(input logic b, input logic [SW_W-1:0] sw, input string tag);
    btn_raw = b;
    sw_raw  = sw;
    @(posedge clk);
    model_step(b, sw);
    @(negedge clk);
    if (step_pulse) n_pulses++;
    chk_all(tag);
  endtask

  task automatic ticks(input logic b, input int n, input string tag);
    for (int i = 0; i < n; i++) tick(b, sw_raw, tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    chk({tag, ".async"}, {step_pulse, btn_level, step_count, sw_sync}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".held"}, {step_pulse, btn_level, step_count, sw_sync}, 32'd0);
    rst = 1'b0;
  endtask

  int pulse_edge;
  logic [15:0] cnt_before;

  initial begin
    assert ((D - 1) < (1 << CW) && (R - 1) < (1 << CW))
      else $fatal(1, "FAIL param_fit CNT_W=%0d too small", CW);
    model_reset();
    n_pulses = 0;
    @(negedge clk);
    do_reset("reset");
    tick(1'b0, '0, "post_reset");

    // 1: clean press; pulse must appear right after edge 6 of the held-high input
    pulse_edge = 0;
    for (int e = 1; e <= 20; e++) begin
      tick(1'b1, '0, "press");
      if (step_pulse && pulse_edge == 0) pulse_edge = e;
    end
    chk("press_latency", pulse_edge, 6);
    chk("press_level", {31'd0, btn_level}, 32'd1);
`ifdef BTN_AUTO_REPEAT_EN
    chk("press_count", {16'd0, step_count}, 32'd2);
`else
    chk("press_count", {16'd0, step_count}, 32'd1);
`endif
    ticks(1'b0, 10, "release");
    chk("release_level", {31'd0, btn_level}, 32'd0);

    // 2: bounce that never reaches D stable samples
    do_reset("reset2");
    ticks(1'b1, 3, "bounce"); ticks(1'b0, 2, "bounce");
    ticks(1'b1, 2, "bounce"); ticks(1'b0, 10, "bounce");
    chk("bounce_count", {16'd0, step_count}, 32'd0);
    chk("bounce_level", {31'd0, btn_level}, 32'd0);

    // 3: release glitch while held
    ticks(1'b1, 8, "glitch_press");
    cnt_before = step_count;
    ticks(1'b0, 2, "glitch"); ticks(1'b1, 6, "glitch");
    chk("glitch_level", {31'd0, btn_level}, 32'd1);
    chk("glitch_count", {16'd0, step_count}, {16'd0, cnt_before});
    ticks(1'b0, 8, "glitch_rel");

    // 4: reset one cycle after entering PRESS_WAIT, then a fresh full press
    ticks(1'b1, 4, "mid_press");
    do_reset("reset_mid");
    ticks(1'b1, 5, "after_rst");
    chk("after_rst_nopulse", {16'd0, step_count}, 32'd0);
    tick(1'b1, sw_raw, "after_rst");
    chk("after_rst_pulse", {31'd0, step_pulse}, 32'd1);
    ticks(1'b0, 8, "after_rst_rel");

    // 5: switch sync latency and count wrap
    tick(1'b0, 6'h2A, "sw0");
    chk("sw_lat1", {26'd0, sw_sync}, 32'h0);
    tick(1'b0, 6'h2A, "sw1");
    chk("sw_lat2", {26'd0, sw_sync}, 32'h2A);
    force dut.r_count = 16'hFFFF;
    #1;
    release dut.r_count;
    m_count = 16'hFFFF;
    ticks(1'b1, 6, "wrap");
    chk("wrap_count", {16'd0, step_count}, 32'h0);
    ticks(1'b0, 8, "wrap_rel");

    // 6: long hold, auto-repeat behaviour
    do_reset("reset6");
    n_pulses = 0;
    ticks(1'b1, 6, "hold");
    ticks(1'b1, 40, "hold");
`ifdef BTN_AUTO_REPEAT_EN
    chk("repeat_pulses", n_pulses, 5);
`else
    chk("repeat_pulses", n_pulses, 1);
`endif
    ticks(1'b0, 8, "hold_rel");

    // random traffic with occasional resets
    for (int k = 0; k < 60; k++) begin
      ticks(1'b1, $urandom_range(1, 14), "rnd_hi");
      for (int j = 0; j < $urandom_range(1, 8); j++)
        tick(1'b0, 6'($urandom), "rnd_lo");
      if ($urandom_range(0, 9) == 0) begin
        ticks(1'b1, $urandom_range(1, 5), "rnd_pre");
        do_reset("rnd_reset");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $fatal(1, "FAIL timeout bench did not finish");
  end

endmodule
